// File: rtl/tempo_strobe_generator_pkg.sv
// Shared timing constants and helpers for the tempo strobe generator.
package tempo_strobe_generator_pkg;

    localparam int unsigned DEFAULT_CLOCK_FREQ = 25_000_000;
    localparam int unsigned DEFAULT_TICK_RATE  = 60;

    // P must hold values up to P + TICK_RATE < 2*CLOCK_FREQ.
    function automatic int unsigned phase_width(input int unsigned clock_freq);
        return $clog2(clock_freq) + 1;
    endfunction

    // Terminal count of a counter whose modulus treats 0 as 1.
    function automatic int unsigned last_index(input int unsigned count);
        return (count == 0) ? 0 : count - 1;
    endfunction

endpackage

// File: rtl/tempo_strobe_generator_divider.sv
// Fractional clock divider: TICK_RATE strobes per CLOCK_FREQ enabled cycles, drift-free.
module phase_accumulator_divider
    import tempo_strobe_generator_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int unsigned TICK_RATE  = DEFAULT_TICK_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic sync,
    output logic strobe
);

    localparam int unsigned PW = phase_width(CLOCK_FREQ);
    localparam logic [PW-1:0] RATE = PW'(TICK_RATE);
    localparam logic [PW-1:0] FREQ = PW'(CLOCK_FREQ);

    if (TICK_RATE == 0 || TICK_RATE >= CLOCK_FREQ) begin : g_bad_rate
        $error("phase_accumulator_divider: TICK_RATE must satisfy 0 < TICK_RATE < CLOCK_FREQ");
    end

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic [PW-1:0] phase_sum;
    logic          tick_cond;

    always_comb begin
        phase_sum = phase_q + RATE;
        tick_cond = (phase_sum >= FREQ);
        phase_d   = phase_q;
        if (sync) begin
            phase_d = '0;
        end else if (enable) begin
            phase_d = tick_cond ? (phase_sum - FREQ) : phase_sum;
        end
    end

    assign strobe = enable & ~sync & tick_cond;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/tempo_strobe_generator.sv
// Tick/beat/bar strobe generator built on a fractional phase-accumulator divider.
module tempo_strobe_generator
    import tempo_strobe_generator_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ  = DEFAULT_CLOCK_FREQ,
    parameter int unsigned TICK_RATE   = DEFAULT_TICK_RATE,
    parameter int unsigned SPEED_WIDTH = 8,
    parameter int unsigned BAR_WIDTH   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_enable,
    input  logic                   i_sync,
    input  logic [SPEED_WIDTH-1:0] i_speed,
    input  logic [BAR_WIDTH-1:0]   i_beats_per_bar,
    output logic                   o_tick_stb,
    output logic                   o_beat_stb,
    output logic                   o_bar_stb,
    output logic [BAR_WIDTH-1:0]   o_beat_index
);

    logic [SPEED_WIDTH-1:0] tick_cnt_q;
    logic [SPEED_WIDTH-1:0] tick_cnt_d;
    logic [BAR_WIDTH-1:0]   beat_index_q;
    logic [BAR_WIDTH-1:0]   beat_index_d;
    logic [SPEED_WIDTH-1:0] speed_last;
    logic [BAR_WIDTH-1:0]   bpb_last;
    logic                   beat_end;
    logic                   bar_end;

    phase_accumulator_divider #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .TICK_RATE  (TICK_RATE)
    ) u_divider (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .enable (i_enable),
        .sync   (i_sync),
        .strobe (o_tick_stb)
    );

    // ">=" rather than "==" so a mid-beat speed drop fires on the next tick.
    always_comb begin
        speed_last   = SPEED_WIDTH'(last_index(32'(i_speed)));
        bpb_last     = BAR_WIDTH'(last_index(32'(i_beats_per_bar)));
        beat_end     = (tick_cnt_q >= speed_last);
        bar_end      = (beat_index_q >= bpb_last);
        tick_cnt_d   = tick_cnt_q;
        beat_index_d = beat_index_q;
        if (i_sync) begin
            tick_cnt_d   = '0;
            beat_index_d = '0;
        end else if (o_tick_stb) begin
            tick_cnt_d = beat_end ? '0 : tick_cnt_q + 1'b1;
            if (beat_end) begin
                beat_index_d = bar_end ? '0 : beat_index_q + 1'b1;
            end
        end
    end

    assign o_beat_stb   = o_tick_stb & beat_end;
    assign o_bar_stb    = o_beat_stb & bar_end;
    assign o_beat_index = beat_index_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt_q   <= '0;
            beat_index_q <= '0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            beat_index_q <= beat_index_d;
        end
    end

endmodule

// File: tb/tb_tempo_strobe_generator.sv
// Directed self-checking bench for tempo_strobe_generator at CLOCK_FREQ=10, TICK_RATE=3.
module tb_tempo_strobe_generator;

    localparam int unsigned CF = 10;
    localparam int unsigned TR = 3;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       sync;
    logic [7:0] speed;
    logic [3:0] bpb;
    logic       tick;
    logic       beat;
    logic       bar;
    logic [3:0] idx;

    int n_checks = 0;
    int n_fail   = 0;

    tempo_strobe_generator #(
        .CLOCK_FREQ  (CF),
        .TICK_RATE   (TR),
        .SPEED_WIDTH (8),
        .BAR_WIDTH   (4)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_sync          (sync),
        .i_speed         (speed),
        .i_beats_per_bar (bpb),
        .o_tick_stb      (tick),
        .o_beat_stb      (beat),
        .o_bar_stb       (bar),
        .o_beat_index    (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed-form schedule: a tick on cycle c when floor(c*TR/CF) steps up.
    function automatic bit exp_tick(input int c);
        return (((c + 1) * TR) / CF) != ((c * TR) / CF);
    endfunction

    // Leaves the bench at a negedge with reset released; that window is cycle 0.
    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        sync   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        sync   = 1'b0;
        speed  = 8'd1;
        bpb    = 4'd1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%b exp=0", tick); end
        n_checks++; if (beat !== 1'b0) begin n_fail++; $display("FAIL reset_beat got=%b exp=0", beat); end
        n_checks++; if (bar !== 1'b0) begin n_fail++; $display("FAIL reset_bar got=%b exp=0", bar); end
        n_checks++; if (idx !== 4'd0) begin n_fail++; $display("FAIL reset_index got=%0d exp=0", idx); end
    endtask

    task automatic test_tick_schedule();
        int first_ticks[7] = '{3, 6, 9, 13, 16, 19, 23};
        int seen[7];
        int n_ticks = 0;
        speed = 8'd1;
        bpb   = 4'd1;
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            #1;
            n_checks++;
            if (tick !== exp_tick(c)) begin
                n_fail++; $display("FAIL tick_sched cycle=%0d got=%b exp=%b", c, tick, exp_tick(c));
            end
            if (tick === 1'b1) begin
                if (n_ticks < 7) seen[n_ticks] = c;
                n_ticks++;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (seen[i] != first_ticks[i]) begin
                n_fail++; $display("FAIL tick_first[%0d] got=%0d exp=%0d", i, seen[i], first_ticks[i]);
            end
        end
        n_checks++;
        if (n_ticks != 300) begin n_fail++; $display("FAIL tick_count_1000 got=%0d exp=300", n_ticks); end
    endtask

    task automatic test_beats_and_bar();
        bit exp_b[7] = '{0, 1, 0, 1, 0, 1, 0};
        bit exp_r[7] = '{0, 0, 0, 0, 0, 1, 0};
        int exp_i[7] = '{0, 0, 1, 1, 2, 2, 0};
        int n = 0;
        speed = 8'd2;
        bpb   = 4'd3;
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c < 25; c++) begin
            #1;
            if (tick === 1'b1 && n < 7) begin
                n_checks++;
                if (beat !== exp_b[n]) begin n_fail++; $display("FAIL beat_tick%0d got=%b exp=%b", n + 1, beat, exp_b[n]); end
                n_checks++;
                if (bar !== exp_r[n]) begin n_fail++; $display("FAIL bar_tick%0d got=%b exp=%b", n + 1, bar, exp_r[n]); end
                n_checks++;
                if (idx !== 4'(exp_i[n])) begin n_fail++; $display("FAIL index_tick%0d got=%0d exp=%0d", n + 1, idx, exp_i[n]); end
                n++;
            end else begin
                n_checks++;
                if (beat !== 1'b0 || bar !== 1'b0) begin
                    n_fail++; $display("FAIL beat_idle cycle=%0d beat=%b bar=%b exp=0", c, beat, bar);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (n != 7) begin n_fail++; $display("FAIL beat_tick_total got=%0d exp=7", n); end
    endtask

    task automatic test_pause();
        bit et;
        bit eb;
        speed = 8'd2;
        bpb   = 4'd4;
        apply_reset();
        for (int c = 0; c <= 16; c++) begin
            enable = !(c >= 5 && c <= 9);
            #1;
            et = (c == 3 || c == 11 || c == 14);
            eb = (c == 11);
            n_checks++;
            if (tick !== et) begin n_fail++; $display("FAIL pause_tick cycle=%0d got=%b exp=%b", c, tick, et); end
            n_checks++;
            if (beat !== eb || bar !== 1'b0) begin
                n_fail++; $display("FAIL pause_beat cycle=%0d beat=%b bar=%b exp_beat=%b exp_bar=0", c, beat, bar, eb);
            end
            @(negedge clk);
        end
        enable = 1'b1;
    endtask

    task automatic test_sync();
        bit et;
        bit eb;
        speed = 8'd2;
        bpb   = 4'd3;
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            sync = (c == 6);
            #1;
            et = (c == 3 || c == 10 || c == 13 || c == 16);
            eb = (c == 13);
            n_checks++;
            if (tick !== et) begin n_fail++; $display("FAIL sync_tick cycle=%0d got=%b exp=%b", c, tick, et); end
            n_checks++;
            if (beat !== eb) begin n_fail++; $display("FAIL sync_beat cycle=%0d got=%b exp=%b", c, beat, eb); end
            @(negedge clk);
        end
        sync = 1'b0;
    endtask

    task automatic test_speed_change();
        bit eb;
        int ei;
        bpb = 4'd8;
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            speed = (c < 10) ? 8'd8 : (c < 14) ? 8'd1 : 8'd0;
            #1;
            eb = (c == 13 || c == 16 || c == 19 || c == 23);
            ei = (c <= 13) ? 0 : (c <= 16) ? 1 : (c <= 19) ? 2 : (c <= 23) ? 3 : 4;
            n_checks++;
            if (beat !== eb) begin n_fail++; $display("FAIL speed_beat cycle=%0d got=%b exp=%b", c, beat, eb); end
            n_checks++;
            if (idx !== 4'(ei)) begin n_fail++; $display("FAIL speed_index cycle=%0d got=%0d exp=%0d", c, idx, ei); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        bit eb;
        int ei;
        speed = 8'd2;
        bpb   = 4'd4;
        apply_reset();
        enable = 1'b1;
        repeat (17) @(negedge clk);
        #1;
        n_checks++;
        if (idx !== 4'd2) begin n_fail++; $display("FAIL areset_pre_index got=%0d exp=2", idx); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (idx !== 4'd0 || tick !== 1'b0 || beat !== 1'b0 || bar !== 1'b0) begin
            n_fail++; $display("FAIL areset_immediate idx=%0d tick=%b beat=%b bar=%b exp=all0", idx, tick, beat, bar);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 24; c++) begin
            #1;
            eb = (c == 6 || c == 13 || c == 19);
            ei = (c <= 6) ? 0 : (c <= 13) ? 1 : (c <= 19) ? 2 : 3;
            n_checks++;
            if (tick !== exp_tick(c)) begin n_fail++; $display("FAIL areset_tick cycle=%0d got=%b exp=%b", c, tick, exp_tick(c)); end
            n_checks++;
            if (beat !== eb || bar !== 1'b0) begin
                n_fail++; $display("FAIL areset_beat cycle=%0d beat=%b bar=%b exp_beat=%b exp_bar=0", c, beat, bar, eb);
            end
            n_checks++;
            if (idx !== 4'(ei)) begin n_fail++; $display("FAIL areset_index cycle=%0d got=%0d exp=%0d", c, idx, ei); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_tick_schedule();
        test_beats_and_bar();
        test_pause();
        test_sync();
        test_speed_change();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
